// File: rtl/bus_wait_memory.sv
// -----------------------------------------------------------------------------
// bus_wait_memory
//   Word-addressed RAM slave for the mips_cpu_bus memory interface. Inserts a
//   fixed or LFSR-driven number of wait states per access, supports byte-lane
//   writes, decodes a base address and flags illegal accesses with a one-cycle
//   error pulse.
//
// Ports
//   clk          in   1   clock, all state on rising edge
//   reset        in   1   asynchronous, active-high reset
//   address      in   32  byte address from master
//   write        in   1   write request
//   read         in   1   read request
//   waitrequest  out  1   1 = master must hold its request unchanged
//   writedata    in   32  write data
//   byteenable   in   4   lane enables, bit0 = bits 7:0 ... bit3 = bits 31:24
//   readdata     out  32  read data, registered
//   error        out  1   one-cycle pulse after an illegal access commits
//
// Memory contents are deliberately outside the reset domain so a bench can
// preload them (hierarchically or over the bus) and keep them across resets.
// -----------------------------------------------------------------------------
module bus_wait_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned RANDOM_WAIT = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        error
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t            r_state;
  logic [3:0]        r_count;
  logic [7:0]        r_lfsr;
  logic [31:0]       r_readdata;
  logic              r_error;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_req;
  logic [3:0]        w_stall;
  logic              w_commit;
  logic              w_waitreq;
  logic [31:0]       w_offset;
  logic              w_zero;
  logic              w_illegal;
  logic [IDX_W-1:0]  w_idx;
  logic              w_mem_we;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1 (taps at bits 7,5,4,3).
  function automatic logic [7:0] f_lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Byte-lane merge; an all-zero enable means a legacy full-word write.
  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
    logic [3:0]  lanes;
    logic [31:0] res;
    lanes = (be == 4'b0000) ? 4'b1111 : be;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  assign w_req = read | write;

  // Stall length for the access presented in IDLE.
  always_comb begin
    w_stall = 4'd0;
    if (RANDOM_WAIT != 0) begin
      w_stall = 4'(32'(r_lfsr[3:0]) % (WAIT_CYCLES + 32'd1));
    end else begin
      w_stall = 4'(WAIT_CYCLES);
    end
  end

  // Address decode. Subtraction is 32-bit unsigned so addresses below the
  // base wrap to huge offsets and fall out of range instead of aliasing.
  always_comb begin
    w_offset  = address - BASE_ADDR;
    w_zero    = (address == 32'd0);
    w_idx     = w_offset[IDX_W+1:2];
    w_illegal = 1'b0;
    if (w_zero) begin
      w_illegal = 1'b0;
    end else if ((read && write) || (address[1:0] != 2'b00) ||
                 (w_offset >= SPAN_BYTES)) begin
      w_illegal = 1'b1;
    end else begin
      w_illegal = 1'b0;
    end
  end

  // Commit happens on the edge where the master sees waitrequest low.
  always_comb begin
    w_commit  = 1'b0;
    w_waitreq = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_waitreq = (w_stall != 4'd0);
          w_commit  = (w_stall == 4'd0);
        end else begin
          w_waitreq = 1'b0;
          w_commit  = 1'b0;
        end
      end
      ST_STALL: begin
        w_waitreq = (r_count != 4'd0);
        w_commit  = w_req && (r_count == 4'd0);
      end
      default: begin
        w_waitreq = 1'b0;
        w_commit  = 1'b0;
      end
    endcase
  end

  // Reset forces waitrequest low at once, even mid-stall.
  assign waitrequest = w_waitreq & ~reset;

  assign w_mem_we = w_commit && write && !w_illegal && !w_zero;

  // Access FSM: stall counter, LFSR and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= 4'd0;
      r_lfsr     <= LFSR_SEED;
      r_readdata <= 32'd0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_lfsr <= f_lfsr_next(r_lfsr);
            if (w_stall != 4'd0) begin
              r_count <= w_stall - 4'd1;
              r_state <= ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (!w_req) begin
            // master abandoned the request: drop it silently
            r_count <= 4'd0;
            r_state <= ST_IDLE;
          end else if (r_count == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: begin
          r_count <= 4'd0;
          r_state <= ST_IDLE;
        end
      endcase

      if (w_commit) begin
        r_error <= w_illegal;
        if (read) begin
          // illegal reads and the idle fetch at address 0 return zero
          r_readdata <= (w_illegal || w_zero) ? 32'd0 : r_mem[w_idx];
        end else begin
          r_readdata <= r_readdata;
        end
      end else begin
        r_error <= 1'b0;
      end
    end
  end

  // Storage array, written only by a legal write commit.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= f_merge(r_mem[w_idx], writedata, byteenable);
    end
  end

  assign readdata = r_readdata;
  assign error    = r_error;

endmodule

// File: tb/tb_bus_wait_memory.sv
module tb_bus_wait_memory;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  rd, wr, waitreq, err;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  be    [3];

  typedef struct {
    int          k;
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mdl [3][DEPTH];
  logic [31:0] exp_rd [3];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] seen_stalls = 16'd0;

  // instance 0: no waits, instance 1: fixed 3, instance 2: random 0..7
  bus_wait_memory #(.WAIT_CYCLES(0), .RANDOM_WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .address(addr[0]), .write(wr[0]), .read(rd[0]),
    .waitrequest(waitreq[0]), .writedata(wdata[0]), .byteenable(be[0]),
    .readdata(rdata[0]), .error(err[0]));

  bus_wait_memory #(.WAIT_CYCLES(3), .RANDOM_WAIT(0)) u_w3 (
    .clk(clk), .reset(reset), .address(addr[1]), .write(wr[1]), .read(rd[1]),
    .waitrequest(waitreq[1]), .writedata(wdata[1]), .byteenable(be[1]),
    .readdata(rdata[1]), .error(err[1]));

  bus_wait_memory #(.WAIT_CYCLES(7), .RANDOM_WAIT(1)) u_rnd (
    .clk(clk), .reset(reset), .address(addr[2]), .write(wr[2]), .read(rd[2]),
    .waitrequest(waitreq[2]), .writedata(wdata[2]), .byteenable(be[2]),
    .readdata(rdata[2]), .error(err[2]));

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference behaviour of one committed access; updates the model memory.
  task automatic model(input int k, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output exp_t e);
    logic [31:0] off;
    logic [3:0]  lanes;
    int          idx;
    off = a - BASE;
    e.k = k; e.is_read = r; e.rdata = 32'd0; e.err = 1'b0;
    if (a != 32'd0) begin
      if ((r && w) || (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH))) begin
        e.err = 1'b1;
      end else begin
        idx = int'(off / 32'd4);
        if (r) e.rdata = mdl[k][idx];
        if (w) begin
          lanes = (b == 4'b0000) ? 4'b1111 : b;
          for (int i = 0; i < 4; i++)
            if (lanes[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
  endtask

  // Issue one access starting at a falling edge; leaves the request asserted
  // so consecutive calls are back-to-back.
  task automatic access(input int k, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    exp_t e;
    int   st;
    model(k, r, w, a, d, b, e);
    exp_q.push_back(e);
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    #1;
    st = 0;
    while (waitreq[k] && st < 40) begin
      @(negedge clk); #1;
      st++;
    end
    if (st >= 40) chk("stall_timeout", 32'(st), 32'd0);
    if (k == 2) begin
      chk("stall_range", 32'(st <= 7), 32'd1);
      seen_stalls[st[3:0]] = 1'b1;
    end else begin
      chk("stall_fixed", 32'(st), (k == 0) ? 32'd0 : 32'd3);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rd = 3'b000; wr = 3'b000;
    @(negedge clk);
  endtask

  // Scoreboard monitor: detect commits from the handshake, then check outputs.
  initial begin
    logic [2:0] pend;
    exp_t       e;
    logic       exp_err;
    forever begin
      @(negedge clk); #2;
      for (int k = 0; k < 3; k++)
        pend[k] = !reset && (rd[k] || wr[k]) && !waitreq[k];
      @(posedge clk); #1;
      if (reset) begin
        for (int k = 0; k < 3; k++) exp_rd[k] = 32'd0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          exp_err = 1'b0;
          if (pend[k]) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL sb_underflow: commit on instance %0d with nothing expected", k);
            end else begin
              e = exp_q.pop_front();
              chk("sb_instance", 32'(k), 32'(e.k));
              exp_err = e.err;
              if (e.is_read) exp_rd[k] = e.rdata;
            end
          end
          chk("readdata", rdata[k], exp_rd[k]);
          chk("error", 32'(err[k]), 32'(exp_err));
        end
      end
    end
  end

  initial begin
    logic r;
    rd = 3'b000; wr = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'd0; wdata[k] = 32'd0; be[k] = 4'd0; exp_rd[k] = 32'd0;
      for (int i = 0; i < DEPTH; i++) mdl[k][i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_waitreq", 32'(waitreq[k]), 32'd0);
      chk("reset_readdata", rdata[k], 32'd0);
      chk("reset_error", 32'(err[k]), 32'd0);
    end
    @(negedge clk);

    // zero-wait instance: directed write/read then random traffic
    access(0, 1'b0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
    access(0, 1'b1, 1'b0, BASE + 32'h10, 32'd0, 4'h0);
    idle();
    for (int i = 0; i < 8; i++) access(0, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 30; i++) begin
      r = 1'($urandom_range(0, 1));
      access(0, r, !r, BASE + 32'(4 * $urandom_range(0, 7)), $urandom,
             4'($urandom_range(0, 15)));
    end
    idle();

    // fixed 3-wait instance: byte lanes, errors, address 0
    access(1, 1'b0, 1'b1, BASE, 32'h11223344, 4'hF);
    access(1, 1'b0, 1'b1, BASE, 32'h0000AA00, 4'b0010);
    access(1, 1'b1, 1'b0, BASE, 32'd0, 4'h0);
    access(1, 1'b0, 1'b1, BASE, 32'h00000055, 4'b0000);
    access(1, 1'b1, 1'b0, BASE, 32'd0, 4'h0);
    access(1, 1'b0, 1'b1, BASE + 32'h8, 32'h01020304, 4'hF);
    access(1, 1'b1, 1'b0, BASE + 32'h8, 32'd0, 4'h0);
    access(1, 1'b1, 1'b0, BASE + 32'h2, 32'd0, 4'h0);
    access(1, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'd0, 4'h0);
    access(1, 1'b1, 1'b0, BASE + 32'h8, 32'd0, 4'h0);
    access(1, 1'b1, 1'b1, BASE, 32'hFFFFFFFF, 4'hF);
    access(1, 1'b0, 1'b1, BASE + 32'h1, 32'hFFFFFFFF, 4'hF);
    access(1, 1'b0, 1'b1, 32'h00000010, 32'hFFFFFFFF, 4'hF);
    access(1, 1'b1, 1'b0, BASE, 32'd0, 4'h0);
    access(1, 1'b1, 1'b0, 32'd0, 32'd0, 4'h0);
    access(1, 1'b0, 1'b1, 32'd0, 32'hFFFFFFFF, 4'hF);
    access(1, 1'b1, 1'b0, BASE, 32'd0, 4'h0);
    idle();

    // reset in the second stall cycle of a write aborts it
    rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = BASE + 32'h8;
    wdata[1] = 32'hCAFEF00D; be[1] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #3 reset = 1'b1;
    #1 chk("abort_waitreq", 32'(waitreq[1]), 32'd0);
    @(negedge clk);
    wr[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    access(1, 1'b1, 1'b0, BASE + 32'h8, 32'd0, 4'h0);
    access(1, 1'b1, 1'b0, BASE + 32'h10, 32'd0, 4'h0);
    idle();

    // random-wait instance: fill memory, then 200 back-to-back reads
    for (int i = 0; i < DEPTH; i++)
      access(2, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 200; i++)
      access(2, 1'b1, 1'b0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 32'd0, 4'h0);
    idle();
    chk("distinct_stalls", 32'($countones(seen_stalls) >= 3), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
